// File: rtl/mem_bus_master.sv
// mem_bus_master: multicycle Avalon-style memory bus sequencer.
// Holds one request on the bus until waitrequest drops, then pulses a response.
module mem_bus_master #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_address,
   input  logic [3:0]  req_byteenable,
   input  logic [31:0] req_writedata,
   output logic        rsp_valid,
   output logic [31:0] rsp_readdata,
   output logic        rsp_error,
   output logic        err_sticky,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam int CW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RDATA,
      S_ERR
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_read;
   logic          r_write;
   logic          w_read_nxt;
   logic          w_write_nxt;
   logic [31:0]   r_address;
   logic [3:0]    r_byteenable;
   logic [31:0]   r_writedata;
   logic          w_latch;
   logic          r_rsp_valid;
   logic          r_rsp_error;
   logic [31:0]   r_rsp_readdata;
   logic          r_err_sticky;
   logic          w_rsp_valid_nxt;
   logic          w_rsp_error_nxt;
   logic [31:0]   w_rsp_readdata_nxt;
   logic          w_err_set;
   logic          w_misalign;
   logic          w_to_hit;

   assign w_misalign = |req_address[1:0];
   assign w_to_hit   = TO_EN && (r_cnt == CNT_LAST);

   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      w_read_nxt         = 1'b0;
      w_write_nxt        = 1'b0;
      w_latch            = 1'b0;
      w_rsp_valid_nxt    = 1'b0;
      w_rsp_error_nxt    = 1'b0;
      w_rsp_readdata_nxt = r_rsp_readdata;
      w_err_set          = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_latch   = 1'b1;
               w_cnt_nxt = '0;
               if (w_misalign) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_state_nxt = S_ACCESS;
                  w_read_nxt  = ~req_write;
                  w_write_nxt = req_write;
               end
            end
         end
         S_ACCESS: begin
            // completion takes priority over a timeout on the same edge
            if (!waitrequest) begin
               if (r_write) begin
                  w_state_nxt     = S_IDLE;
                  w_rsp_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_RDATA;
               end
            end else if (w_to_hit) begin
               w_state_nxt = S_ERR;
            end else begin
               w_read_nxt  = r_read;
               w_write_nxt = r_write;
               if (r_cnt != CNT_MAX) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         S_RDATA: begin
            w_state_nxt        = S_IDLE;
            w_rsp_valid_nxt    = 1'b1;
            w_rsp_readdata_nxt = readdata;
         end
         S_ERR: begin
            w_state_nxt        = S_IDLE;
            w_rsp_valid_nxt    = 1'b1;
            w_rsp_error_nxt    = 1'b1;
            w_rsp_readdata_nxt = '0;
            w_err_set          = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_read         <= 1'b0;
         r_write        <= 1'b0;
         r_address      <= '0;
         r_byteenable   <= '0;
         r_writedata    <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_error    <= 1'b0;
         r_rsp_readdata <= '0;
         r_err_sticky   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_read         <= w_read_nxt;
         r_write        <= w_write_nxt;
         r_rsp_valid    <= w_rsp_valid_nxt;
         r_rsp_error    <= w_rsp_error_nxt;
         r_rsp_readdata <= w_rsp_readdata_nxt;
         if (w_latch) begin
            r_address    <= req_address;
            r_byteenable <= req_byteenable;
            r_writedata  <= req_writedata;
         end
         if (w_err_set) begin
            r_err_sticky <= 1'b1;
         end
      end
   end

   assign req_ready    = (r_state == S_IDLE);
   assign rsp_valid    = r_rsp_valid;
   assign rsp_error    = r_rsp_error;
   assign rsp_readdata = r_rsp_readdata;
   assign err_sticky   = r_err_sticky;
   assign address      = r_address;
   assign read         = r_read;
   assign write        = r_write;
   assign byteenable   = r_byteenable;
   assign writedata    = r_writedata;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: randomized self-checking bench for mem_bus_master.
// Expected timing comes from per-transaction latency arithmetic.
module tb_mem_bus_master;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_address;
   logic [3:0]  req_byteenable;
   logic [31:0] req_writedata;
   logic        rsp_valid;
   logic [31:0] rsp_readdata;
   logic        rsp_error;
   logic        err_sticky;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   int total = 0;
   int bad = 0;
   logic [31:0] m_rdata;
   logic        m_sticky;

   always #5 clk = ~clk;

   mem_bus_master #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_address(req_address),
      .req_byteenable(req_byteenable),
      .req_writedata(req_writedata),
      .rsp_valid(rsp_valid),
      .rsp_readdata(rsp_readdata),
      .rsp_error(rsp_error),
      .err_sticky(err_sticky),
      .address(address),
      .read(read),
      .write(write),
      .byteenable(byteenable),
      .writedata(writedata),
      .waitrequest(waitrequest),
      .readdata(readdata)
   );

   // Call at a negedge with the DUT idle; returns at the response negedge.
   task automatic run_txn(input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd,
                          input string tag);
      logic misal;
      logic to;
      logic err;
      logic on;
      int   lat;
      int   last_on;
      misal = (addr[1:0] != 2'b00);
      to = !misal && (waits >= T);
      err = misal || to;
      if (misal) lat = 1;
      else if (to) lat = T + 1;
      else if (wr) lat = waits + 1;
      else lat = waits + 2;
      last_on = misal ? -1 : (to ? T - 1 : waits);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready: got=%b want=1", tag, req_ready);
      end
      req_valid = 1'b1;
      req_write = wr;
      req_address = addr;
      req_byteenable = be;
      req_writedata = wd;
      waitrequest = 1'($urandom_range(0, 1));
      readdata = $urandom;
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         on = (k <= last_on);
         total++;
         if (read !== (on && !wr) || write !== (on && wr)) begin
            bad++;
            $display("FAIL %s strobe k=%0d: rd=%b wr=%b want rd=%b wr=%b",
                     tag, k, read, write, on && !wr, on && wr);
         end
         if (on) begin
            total++;
            if (address !== addr || byteenable !== be ||
                writedata !== wd) begin
               bad++;
               $display("FAIL %s bus k=%0d: a=%h be=%b d=%h want %h %b %h",
                        tag, k, address, byteenable, writedata,
                        addr, be, wd);
            end
         end
         total++;
         if (rsp_valid !== (k == lat)) begin
            bad++;
            $display("FAIL %s rsp_valid k=%0d: got=%b want=%b",
                     tag, k, rsp_valid, k == lat);
         end
         if (k == lat) begin
            if (err) begin
               m_rdata = 32'h0;
               m_sticky = 1'b1;
            end else if (!wr) begin
               m_rdata = rd;
            end
            total++;
            if (rsp_error !== err) begin
               bad++;
               $display("FAIL %s rsp_error: got=%b want=%b",
                        tag, rsp_error, err);
            end
            total++;
            if (rsp_readdata !== m_rdata) begin
               bad++;
               $display("FAIL %s rsp_readdata: got=%h want=%h",
                        tag, rsp_readdata, m_rdata);
            end
            total++;
            if (err_sticky !== m_sticky || req_ready !== 1'b1) begin
               bad++;
               $display("FAIL %s sticky/ready: got=%b/%b want=%b/1",
                        tag, err_sticky, req_ready, m_sticky);
            end
         end
         req_valid = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
         req_write = 1'($urandom_range(0, 1));
         req_address = $urandom;
         req_byteenable = 4'($urandom);
         req_writedata = $urandom;
         if (k + 1 <= waits) waitrequest = 1'b1;
         else if (k + 1 == waits + 1) waitrequest = 1'b0;
         else waitrequest = 1'($urandom_range(0, 1));
         readdata = (!wr && !err && k == waits + 1) ? rd : $urandom;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0;
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
            bad++;
            $display("FAIL idle: rsp_valid=%b read=%b write=%b want 0",
                     rsp_valid, read, write);
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_address = '0;
      req_byteenable = '0;
      req_writedata = '0;
      waitrequest = 1'b0;
      readdata = '0;
      m_rdata = '0;
      m_sticky = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (read !== 1'b0 || write !== 1'b0 || rsp_valid !== 1'b0 ||
          rsp_error !== 1'b0 || err_sticky !== 1'b0) begin
         bad++;
         $display("FAIL reset flags: rd=%b wr=%b v=%b e=%b s=%b want 0",
                  read, write, rsp_valid, rsp_error, err_sticky);
      end
      total++;
      if (address !== 32'h0 || writedata !== 32'h0 ||
          rsp_readdata !== 32'h0 || byteenable !== 4'h0) begin
         bad++;
         $display("FAIL reset data: a=%h d=%h r=%h be=%b want 0",
                  address, writedata, rsp_readdata, byteenable);
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset ready: got=%b want=1", req_ready);
      end
      reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_read_basic;
      run_txn(1'b0, 32'h0000_1004, 4'b1111, 32'h1234_5678, 0,
              32'hDEAD_BEEF, "read_basic");
      idle(1);
      run_txn(1'b0, 32'h0000_1008, 4'b0011, 32'h0, 3,
              32'hCAFE_F00D, "read_wait3");
      idle(1);
   endtask

   task automatic test_write_wait;
      run_txn(1'b1, 32'h0000_2000, 4'b0100, 32'h00AB_0000, 4,
              32'h0, "write_wait4");
      idle(1);
      run_txn(1'b1, 32'h0000_2004, 4'b0000, 32'h5555_AAAA, 0,
              32'h0, "write_be0");
      idle(1);
   endtask

   task automatic test_misaligned;
      run_txn(1'b0, 32'h0000_3002, 4'b1111, 32'h0, 0,
              32'h0, "misaligned_rd");
      idle(1);
      run_txn(1'b1, 32'h0000_3001, 4'b0001, 32'hFF, 2,
              32'h0, "misaligned_wr");
      idle(1);
   endtask

   task automatic test_timeout;
      run_txn(1'b0, 32'h0000_0040, 4'b1111, 32'h0, 40,
              32'h1111_1111, "timeout_rd");
      idle(1);
      run_txn(1'b1, 32'h0000_0044, 4'b1111, 32'h7777_0000, T,
              32'h0, "timeout_wr");
      idle(1);
      run_txn(1'b1, 32'h0000_0048, 4'b1000, 32'hAA00_0000, T - 1,
              32'h0, "edge_wr");
      idle(1);
      run_txn(1'b0, 32'h0000_004C, 4'b1111, 32'h0, T - 1,
              32'h2468_ACE0, "edge_rd");
      idle(1);
   endtask

   task automatic test_back_to_back;
      run_txn(1'b1, 32'h0000_5000, 4'b1111, 32'hA5A5_A5A5, 0,
              32'h0, "b2b_wr");
      run_txn(1'b0, 32'h0000_5000, 4'b1111, 32'h0, 0,
              32'h0BAD_F00D, "b2b_rd");
      for (int i = 0; i < 3; i++) begin
         run_txn(1'b0, 32'h0000_6000 + 32'(i * 4), 4'b1111, 32'h0, 0,
                 $urandom, "b2b_rd_chain");
      end
      idle(1);
   endtask

   task automatic test_random;
      logic [31:0] a;
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         run_txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
                 int'($urandom_range(0, 10)), $urandom, "random");
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      idle(1);
   endtask

   task automatic test_reset_mid_access;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_address = 32'h0000_7000;
      req_byteenable = 4'b1111;
      req_writedata = 32'h0;
      waitrequest = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (read !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset pre: read=%b want=1", read);
      end
      #2 reset_n = 1'b0;
      #1;
      m_rdata = 32'h0;
      m_sticky = 1'b0;
      total++;
      if (read !== 1'b0 || rsp_valid !== 1'b0 || err_sticky !== 1'b0 ||
          rsp_error !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset flags: rd=%b v=%b s=%b e=%b want 0",
                  read, rsp_valid, err_sticky, rsp_error);
      end
      total++;
      if (address !== 32'h0 || byteenable !== 4'h0 ||
          writedata !== 32'h0 || rsp_readdata !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset data: a=%h be=%b d=%h r=%h want 0",
                  address, byteenable, writedata, rsp_readdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      waitrequest = 1'b0;
      idle(4);
      run_txn(1'b0, 32'h0000_7004, 4'b1111, 32'h0, 1,
              32'h1357_9BDF, "post_reset_rd");
      idle(1);
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_wait();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
